// File: rtl/stim_expect_sequencer.sv
// Run controller for a stimulus/expect vector-memory pair: header check, stimulus issue, latency-aligned compare.
// Optional build macro STIM_SEQ_STOP_ON_MISMATCH_EN halts new reads after the first compare failure.
module stim_expect_sequencer #(
  parameter int WIDTH       = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int DUT_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vectors,
  input  logic                 stall,
  output logic                 stim_rd_en,
  output logic                 exp_rd_en,
  input  logic                 stim_id_err,
  input  logic                 stim_version_err,
  input  logic                 exp_id_err,
  input  logic                 exp_version_err,
  input  logic [WIDTH-1:0]     stim_vector,
  input  logic [WIDTH-1:0]     exp_vector,
  output logic [WIDTH-1:0]     dut_in,
  output logic                 dut_in_valid,
  input  logic [WIDTH-1:0]     dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 hdr_err,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic [CNT_WIDTH-1:0] vector_count,
  output logic [CNT_WIDTH-1:0] first_mismatch
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR0   = 3'd1;
  localparam logic [2:0] S_HDR1   = 3'd2;
  localparam logic [2:0] S_HDRCHK = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] num_q;
  logic                 id_err_q;
  logic                 issue;
  logic                 rd_en;
  logic                 hdr_fail;
  logic                 stop_gate;
  logic                 pass_next;
  logic                 cmp_valid;
  logic                 cmp_miss;

  // Stage 0 lines up with dut_in; stage DUT_LATENCY lines up with dut_out.
  logic [WIDTH-1:0]     exp_pipe [0:DUT_LATENCY];
  logic [DUT_LATENCY:0] vld_pipe;

  assign hdr_fail     = id_err_q | stim_version_err | exp_version_err;
  assign cmp_valid    = vld_pipe[DUT_LATENCY];
  assign cmp_miss     = cmp_valid && (dut_out != exp_pipe[DUT_LATENCY]);
  assign dut_in_valid = vld_pipe[0];
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH);
  assign stim_rd_en   = rd_en;
  assign exp_rd_en    = rd_en;

`ifdef STIM_SEQ_STOP_ON_MISMATCH_EN
  logic stop_q;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      stop_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      stop_q <= 1'b0;
    end else if (cmp_miss) begin
      stop_q <= 1'b1;
    end
  end

  assign stop_gate = stop_q;
`else
  assign stop_gate = 1'b0;
`endif

  always_comb begin
    rd_en = 1'b0;
    case (state)
      S_HDR0, S_HDR1: rd_en = 1'b1;
      S_RUN:          rd_en = ~stall & (remaining != CNT_ZERO) & ~stop_gate;
      default:        rd_en = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_HDR0;
      S_HDR0:   next_state = S_HDR1;
      S_HDR1:   next_state = S_HDRCHK;
      S_HDRCHK: next_state = (hdr_fail || num_q == CNT_ZERO) ? S_FINISH : S_RUN;
      S_RUN: begin
        if (stop_gate || (remaining == CNT_ZERO && !issue)) next_state = S_DRAIN;
      end
      S_DRAIN:  if (!issue && vld_pipe == '0) next_state = S_FINISH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Result is settled on the edge into FINISH so pass is valid alongside done.
  assign pass_next = ~(hdr_err | (state == S_HDRCHK && hdr_fail))
                   & (mismatch_count == CNT_ZERO)
                   & (vector_count == num_q);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state     <= S_IDLE;
      remaining <= '0;
      num_q     <= '0;
      id_err_q  <= 1'b0;
      issue     <= 1'b0;
      pass      <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      state <= next_state;
      issue <= rd_en && (state == S_RUN);
      if (state == S_IDLE && start) begin
        remaining <= num_vectors;
        num_q     <= num_vectors;
        pass      <= 1'b0;
        hdr_err   <= 1'b0;
      end
      if (state == S_RUN && rd_en) begin
        remaining <= remaining - CNT_ONE;
      end
      if (state == S_HDR1) begin
        id_err_q <= stim_id_err | exp_id_err;
      end
      if (state == S_HDRCHK && hdr_fail) begin
        hdr_err <= 1'b1;
      end
      if (state != S_FINISH && next_state == S_FINISH) begin
        pass <= pass_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      dut_in   <= '0;
      vld_pipe <= '0;
      for (int i = 0; i <= DUT_LATENCY; i++) begin
        exp_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= issue;
      if (issue) begin
        dut_in      <= stim_vector;
        exp_pipe[0] <= exp_vector;
      end
      for (int i = 1; i <= DUT_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  // Counters saturate; first_mismatch records the compare index before the increment.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      mismatch_count <= '0;
      vector_count   <= '0;
      first_mismatch <= '0;
    end else if (state == S_IDLE && start) begin
      mismatch_count <= '0;
      vector_count   <= '0;
      first_mismatch <= '0;
    end else if (cmp_valid) begin
      if (vector_count != CNT_MAX) begin
        vector_count <= vector_count + CNT_ONE;
      end
      if (cmp_miss) begin
        if (mismatch_count == CNT_ZERO) begin
          first_mismatch <= vector_count;
        end
        if (mismatch_count != CNT_MAX) begin
          mismatch_count <= mismatch_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_stim_expect_sequencer.sv
// Directed bench for stim_expect_sequencer: behavioural vector memories and an identity DUT of latency 1.
module tb_stim_expect_sequencer;
  localparam int WIDTH = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset_;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          stall;
  logic          stim_rd_en, exp_rd_en;
  logic          stim_id_err, stim_version_err, exp_id_err, exp_version_err;
  logic [WIDTH-1:0] stim_vector, exp_vector, dut_in, dut_out;
  logic          dut_in_valid, busy, done, pass, hdr_err;
  logic [CW-1:0] mismatch_count, vector_count, first_mismatch;

  logic [WIDTH-1:0] stim_mem [DEPTH];
  logic [WIDTH-1:0] exp_mem  [DEPTH];
  logic [3:0]       mem_addr;

  int checks   = 0;
  int failures = 0;
  int rd_count = 0, done_count = 0, valid_count = 0, rd_pair_bad = 0, stalled_rd = 0;

  stim_expect_sequencer #(.WIDTH(WIDTH), .CNT_WIDTH(CW), .DUT_LATENCY(1)) dut (
    .clock(clock), .reset_(reset_), .start(start), .num_vectors(num_vectors), .stall(stall),
    .stim_rd_en(stim_rd_en), .exp_rd_en(exp_rd_en),
    .stim_id_err(stim_id_err), .stim_version_err(stim_version_err),
    .exp_id_err(exp_id_err), .exp_version_err(exp_version_err),
    .stim_vector(stim_vector), .exp_vector(exp_vector),
    .dut_in(dut_in), .dut_in_valid(dut_in_valid), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .hdr_err(hdr_err),
    .mismatch_count(mismatch_count), .vector_count(vector_count), .first_mismatch(first_mismatch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Identity DUT with one cycle of latency.
  always @(posedge clock or negedge reset_) begin
    if (!reset_) dut_out <= '0;
    else         dut_out <= dut_in;
  end

  // Vector memories: registered read, header flags raised when words 0/1 are read.
  always @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      mem_addr <= '0; stim_vector <= '0; exp_vector <= '0;
      stim_id_err <= 1'b0; exp_id_err <= 1'b0; stim_version_err <= 1'b0; exp_version_err <= 1'b0;
    end else if (start && !busy) begin
      mem_addr <= '0;
    end else if (stim_rd_en) begin
      stim_vector <= stim_mem[mem_addr];
      exp_vector  <= exp_mem[mem_addr];
      mem_addr    <= mem_addr + 4'd1;
      if (mem_addr == 4'd0) begin
        stim_id_err <= (stim_mem[0] != 8'd5);
        exp_id_err  <= (exp_mem[0] != 8'd5);
      end
      if (mem_addr == 4'd1) begin
        stim_version_err <= (stim_mem[1] != 8'd2);
        exp_version_err  <= (exp_mem[1] != 8'd2);
      end
    end
  end

  always @(posedge clock) begin
    if (stim_rd_en) rd_count++;
    if (stim_rd_en !== exp_rd_en) rd_pair_bad++;
    if (stim_rd_en && stall) stalled_rd++;
    if (done) done_count++;
    if (dut_in_valid) valid_count++;
  end

  task automatic load_mems(input logic [7:0] exp_ver, input int bad_idx);
    for (int i = 0; i < DEPTH; i++) begin
      stim_mem[i] = 8'(8'h30 + i * 7);
      exp_mem[i]  = 8'(8'h30 + i * 7);
    end
    stim_mem[0] = 8'd5; exp_mem[0] = 8'd5;
    stim_mem[1] = 8'd2; exp_mem[1] = exp_ver;
    if (bad_idx >= 0) exp_mem[bad_idx + 2] = exp_mem[bad_idx + 2] ^ 8'hFF;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    @(negedge clock);
    num_vectors = n;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0; start = 1'b0; stall = 1'b0; num_vectors = '0;
    load_mems(8'd2, -1);
    #12;
    checks++;
    if ({busy, done, pass, hdr_err, dut_in_valid, stim_rd_en} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {busy, done, pass, hdr_err, dut_in_valid, stim_rd_en});
    end
    checks++;
    if ({mismatch_count, vector_count, first_mismatch} !== 48'd0 || dut_in !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters: got mm=%0d vc=%0d fm=%0d dut_in=%0d expected all 0", mismatch_count, vector_count, first_mismatch, dut_in);
    end
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_normal();
    int r0, d0;
    bit seen;
    load_mems(8'd2, -1);
    r0 = rd_count; d0 = done_count;
    pulse_start(16'd4);
    wait_done(60, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL normal_done: got no done expected done within 60 cycles"); end
    checks++;
    if (rd_count - r0 !== 6) begin failures++; $display("[TB] FAIL normal_rd_pulses: got %0d expected 6", rd_count - r0); end
    checks++;
    if (vector_count !== 16'd4) begin failures++; $display("[TB] FAIL normal_vector_count: got %0d expected 4", vector_count); end
    checks++;
    if (mismatch_count !== 16'd0) begin failures++; $display("[TB] FAIL normal_mismatch_count: got %0d expected 0", mismatch_count); end
    checks++;
    if (pass !== 1'b1 || hdr_err !== 1'b0) begin failures++; $display("[TB] FAIL normal_pass: got pass=%b hdr_err=%b expected 1/0", pass, hdr_err); end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL normal_done_pulses: got %0d expected 1", done_count - d0); end
    checks++;
    if (busy !== 1'b0 || pass !== 1'b1) begin failures++; $display("[TB] FAIL normal_idle_after: got busy=%b pass=%b expected 0/1", busy, pass); end
  endtask

  task automatic test_hdr_err();
    int r0;
    bit seen;
    load_mems(8'd3, -1);
    r0 = rd_count;
    pulse_start(16'd4);
    wait_done(30, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL hdr_done: got no done expected done within 30 cycles"); end
    checks++;
    if (hdr_err !== 1'b1 || pass !== 1'b0) begin failures++; $display("[TB] FAIL hdr_flags: got hdr_err=%b pass=%b expected 1/0", hdr_err, pass); end
    checks++;
    if (rd_count - r0 !== 2) begin failures++; $display("[TB] FAIL hdr_rd_pulses: got %0d expected 2", rd_count - r0); end
    checks++;
    if (vector_count !== 16'd0) begin failures++; $display("[TB] FAIL hdr_vector_count: got %0d expected 0", vector_count); end
    @(negedge clock);
  endtask

  task automatic test_mismatch();
    bit seen;
    load_mems(8'd2, 2);
    pulse_start(16'd8);
    wait_done(80, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL mm_done: got no done expected done within 80 cycles"); end
    checks++;
    if (mismatch_count !== 16'd1) begin failures++; $display("[TB] FAIL mm_count: got %0d expected 1", mismatch_count); end
    checks++;
    if (first_mismatch !== 16'd2) begin failures++; $display("[TB] FAIL mm_first: got %0d expected 2", first_mismatch); end
    checks++;
    if (pass !== 1'b0) begin failures++; $display("[TB] FAIL mm_pass: got %b expected 0", pass); end
`ifdef STIM_SEQ_STOP_ON_MISMATCH_EN
    checks++;
    if (vector_count >= 16'd8) begin failures++; $display("[TB] FAIL mm_vector_count: got %0d expected below 8", vector_count); end
`else
    checks++;
    if (vector_count !== 16'd8) begin failures++; $display("[TB] FAIL mm_vector_count: got %0d expected 8", vector_count); end
`endif
    @(negedge clock);
  endtask

  task automatic test_stall();
    int r0, v0, s0;
    bit seen;
    load_mems(8'd2, -1);
    r0 = rd_count; v0 = valid_count; s0 = stalled_rd;
    pulse_start(16'd6);
    for (int i = 0; i < 30; i++) begin
      if (rd_count - r0 >= 4) break;
      @(negedge clock);
    end
    stall = 1'b1;
    #1;
    checks++;
    if (stim_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL stall_rd_immediate: got %b expected 0", stim_rd_en); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 2) begin
        checks++;
        if (dut_in_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_bubble: got dut_in_valid=%b expected 0", dut_in_valid); end
      end
    end
    stall = 1'b0;
    wait_done(60, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL stall_done: got no done expected done within 60 cycles"); end
    checks++;
    if (stalled_rd - s0 !== 0) begin failures++; $display("[TB] FAIL stall_rd_while_stalled: got %0d expected 0", stalled_rd - s0); end
    checks++;
    if (vector_count !== 16'd6 || pass !== 1'b1) begin failures++; $display("[TB] FAIL stall_result: got vc=%0d pass=%b expected 6/1", vector_count, pass); end
    checks++;
    if (valid_count - v0 !== 6 || rd_count - r0 !== 8) begin
      failures++;
      $display("[TB] FAIL stall_traffic: got valid=%0d rd=%0d expected 6/8", valid_count - v0, rd_count - r0);
    end
    @(negedge clock);
  endtask

  task automatic test_zero_and_busy_start();
    int r0, d0;
    bit seen;
    load_mems(8'd2, -1);
    r0 = rd_count; d0 = done_count;
    pulse_start(16'd0);
    num_vectors = 16'd5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(20, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL zero_done: got no done expected done within 20 cycles"); end
    checks++;
    if (pass !== 1'b1 || vector_count !== 16'd0) begin failures++; $display("[TB] FAIL zero_result: got pass=%b vc=%0d expected 1/0", pass, vector_count); end
    for (int i = 0; i < 4; i++) @(negedge clock);
    checks++;
    if (rd_count - r0 !== 2 || done_count - d0 !== 1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_busy_start_ignored: got rd=%0d done=%0d busy=%b expected 2/1/0", rd_count - r0, done_count - d0, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int r0, d0;
    bit seen;
    load_mems(8'd2, -1);
    r0 = rd_count;
    pulse_start(16'd8);
    for (int i = 0; i < 30; i++) begin
      if (rd_count - r0 >= 5) break;
      @(negedge clock);
    end
    #2;
    d0 = done_count;
    reset_ = 1'b0;
    #1;
    checks++;
    if ({busy, stim_rd_en, dut_in_valid, done} !== 4'b0 || vector_count !== 16'd0 || dut_in !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midrun_reset_outputs: got busy=%b rd=%b v=%b done=%b vc=%0d dut_in=%0d expected all 0",
               busy, stim_rd_en, dut_in_valid, done, vector_count, dut_in);
    end
    for (int i = 0; i < 3; i++) @(negedge clock);
    reset_ = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clock);
    checks++;
    if (done_count - d0 !== 0) begin failures++; $display("[TB] FAIL midrun_no_done: got %0d expected 0", done_count - d0); end
    pulse_start(16'd3);
    wait_done(60, seen);
    checks++;
    if (!seen || pass !== 1'b1 || vector_count !== 16'd3 || mismatch_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midrun_rerun: got seen=%b pass=%b vc=%0d mm=%0d expected 1/1/3/0", seen, pass, vector_count, mismatch_count);
    end
    @(negedge clock);
  endtask

  task automatic test_rd_en_pairing();
    checks++;
    if (rd_pair_bad !== 0) begin failures++; $display("[TB] FAIL rd_en_pairing: got %0d unequal cycles expected 0", rd_pair_bad); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hdr_err();
    test_mismatch();
    test_stall();
    test_zero_and_busy_start();
    test_reset_mid_run();
    test_rd_en_pairing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
